seg_shift_ctrl: RTL and testbench

SEG_SHIFT_CTRL -- requirements
Module: seg_shift_ctrl

---
 rtl/seg_shift_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg_shift_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_shift_ctrl.sv
// Serial shift-register driver: clears the external register, then shifts each accepted
// pattern out MSB first and strobes seg_pen. Optional auto-refresh: SEG_SHIFT_AUTO_REFRESH_EN.
module seg_shift_ctrl #(
  parameter int DATA_W      = 64,
  parameter int CLK_DIV     = 4,
  parameter int REFRESH_CYC = 1000000
) (
  input  logic              SI_ClkIn,
  input  logic              SI_Reset_N,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy,
  output logic              done,
  output logic              seg_clk,
  output logic              seg_do,
  output logic              seg_pen,
  output logic              seg_clr_n
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_CLR, S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_done, w_done_nxt;
  logic              w_accept;
  logic              w_start;
  logic [DATA_W-1:0] w_start_data;

  assign w_accept = load_valid && load_ready;

`ifdef SEG_SHIFT_AUTO_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_CYC + 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYC - 1);

  logic [REF_W-1:0]  r_ref_cnt;
  logic [DATA_W-1:0] r_retain;
  logic              w_refresh;

  // A real load in the trigger cycle takes priority over the refresh.
  assign w_refresh    = (r_state == S_IDLE) && !w_accept && (r_ref_cnt == REF_LAST);
  assign w_start      = w_accept || w_refresh;
  assign w_start_data = w_accept ? load_data : r_retain;

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      r_ref_cnt <= '0;
      r_retain  <= '0;
    end else begin
      if (w_accept) r_retain <= load_data;
      if ((r_state != S_IDLE) || w_start) r_ref_cnt <= '0;
      else                                r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end
`else
  assign w_start      = w_accept;
  assign w_start_data = load_data;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the shift register is reset too, so seg_do and any retained data are defined after reset.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      r_state <= S_CLR;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_CLR: begin
        if (r_div == DIV_LAST) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = w_start_data;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt   = '0;
          w_shift_nxt = r_shift << 1;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = S_LATCH;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (r_div == LATCH_LAST) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: w_state_nxt = S_CLR;
    endcase
  end

  // Outputs decode straight from flops so reset drives them asynchronously.
  assign load_ready = (r_state == S_IDLE);
  assign busy       = !load_ready;
  assign done       = r_done;
  assign seg_clr_n  = (r_state != S_CLR);
  assign seg_pen    = !((r_state == S_SHIFT) || (r_state == S_LATCH));
  assign seg_clk    = (r_state == S_SHIFT) && (r_div >= DIV_HALF);
  assign seg_do     = (r_state == S_SHIFT) && r_shift[DATA_W-1];

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Self-checking bench for seg_shift_ctrl: a 64-bit/CLK_DIV=2 instance and an 8-bit/CLK_DIV=1
// instance, checked against frame expectations derived from the pattern bit order and timing rules.
module tb_seg_shift_ctrl;

  typedef struct packed {
    logic clk;
    logic dout;
    logic pen;
    logic clr_n;
    logic rdy;
    logic busy;
    logic done;
  } outs_t;

  typedef struct {
    int          sel;
    logic [63:0] data;
    int          exp_lat;
    logic [63:0] exp_stream;
    int          exp_rises;
  } vec_t;

  localparam outs_t RST_OUTS = 7'b0010010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_b = 1'b0;
  logic [63:0] data_b  = '0;
  logic        rdy_b, busy_b, done_b, sclk_b, sdo_b, pen_b, clr_b;
  logic        valid_s = 1'b0;
  logic [7:0]  data_s  = '0;
  logic        rdy_s, busy_s, done_s, sclk_s, sdo_s, pen_s, clr_s;

  int n_checks = 0;
  int n_fail   = 0;

  seg_shift_ctrl #(.DATA_W(64), .CLK_DIV(2), .REFRESH_CYC(50)) u_big (
    .SI_ClkIn(clk), .SI_Reset_N(rst_n), .load_valid(valid_b), .load_data(data_b),
    .load_ready(rdy_b), .busy(busy_b), .done(done_b), .seg_clk(sclk_b), .seg_do(sdo_b),
    .seg_pen(pen_b), .seg_clr_n(clr_b)
  );

  seg_shift_ctrl #(.DATA_W(8), .CLK_DIV(1), .REFRESH_CYC(1000000)) u_small (
    .SI_ClkIn(clk), .SI_Reset_N(rst_n), .load_valid(valid_s), .load_data(data_s),
    .load_ready(rdy_s), .busy(busy_s), .done(done_s), .seg_clk(sclk_s), .seg_do(sdo_s),
    .seg_pen(pen_s), .seg_clr_n(clr_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic outs_t get(input int sel);
    outs_t o;
    if (sel == 0) o = {sclk_b, sdo_b, pen_b, clr_b, rdy_b, busy_b, done_b};
    else          o = {sclk_s, sdo_s, pen_s, clr_s, rdy_s, busy_s, done_s};
    return o;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [63:0] d);
    if (sel == 0) begin
      valid_b = v;
      data_b  = d;
    end else begin
      valid_s = v;
      data_s  = d[7:0];
    end
  endtask

  // Reference: bits leave MSB first, one seg_clk rise each; timing from the frame rules.
  function automatic vec_t model(input int sel, input logic [63:0] d);
    vec_t v;
    bit   q[$];
    int   w   = (sel == 0) ? 64 : 8;
    int   div = (sel == 0) ? 2 : 1;
    for (int i = w - 1; i >= 0; i--) q.push_back(d[i]);
    v.sel        = sel;
    v.data       = d;
    v.exp_lat    = 1 + w * 2 * div + div;
    v.exp_rises  = q.size();
    v.exp_stream = '0;
    foreach (q[i]) v.exp_stream = {v.exp_stream[62:0], q[i]};
    return v;
  endfunction

  // Presents a pattern (unless already presented), then watches the frame until done.
  task automatic run_frame(input int sel, input logic [63:0] data, input bit presented,
                           input bit hold, input logic [63:0] next_data,
                           output int lat, output logic [63:0] stream,
                           output int rises, output int bad);
    outs_t o;
    logic  prev_clk = 1'b0;
    lat = 0; stream = '0; rises = 0; bad = 0;
    if (!presented) begin
      drive(sel, 1'b1, data);
      for (int i = 0; i < 2000; i++) begin
        o = get(sel);
        if (o.rdy) break;
        @(negedge clk);
      end
      o = get(sel);
      if (!o.rdy) bad++;
    end
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) drive(sel, 1'b1, next_data);
        else      drive(sel, 1'b0, '0);
      end
      o = get(sel);
      if (o.clk && !prev_clk) begin
        rises++;
        stream = {stream[62:0], o.dout};
      end
      prev_clk = o.clk;
      if (o.busy == o.rdy) bad++;
      if (o.done) begin
        lat = k;
        break;
      end
      if (o.pen || o.rdy || !o.clr_n) bad++;
    end
  endtask

  task automatic clear_seq(input string tag);
    int    first[2];
    int    bad = 0;
    outs_t o;
    first[0] = 0;
    first[1] = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        o = get(s);
        if (first[s] == 0) begin
          if (o.clr_n) begin
            first[s] = k;
            if (!o.rdy) bad++;
          end else if (o.rdy || !o.busy) begin
            bad++;
          end
        end
        if (!o.pen || o.clk || o.done) bad++;
      end
    end
    check({tag, "_clr_len_big"}, 64'(first[0]), 64'd4);
    check({tag, "_clr_len_small"}, 64'(first[1]), 64'd2);
    check({tag, "_clr_quiet"}, 64'(bad), 64'd0);
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int lat,
                             input logic [63:0] stream, input int rises, input int bad);
    outs_t o = get(v.sel);
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_stream"}, stream, v.exp_stream);
    check({tag, "_rises"}, 64'(rises), 64'(v.exp_rises));
    check({tag, "_in_frame"}, 64'(bad), 64'd0);
    check({tag, "_pen_at_done"}, 64'(o.pen), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    int          lat, rises, bad;
    logic [63:0] stream;
    outs_t       o;
    logic [63:0] a5 = 64'hA5A5_A5A5_A5A5_A5A5;

    vecs.push_back('{0, 64'h8000_0000_0000_0001, 259, 64'h8000_0000_0000_0001, 64});
    vecs.push_back('{1, 64'h5A, 18, 64'h5A, 8});
    vecs.push_back('{1, 64'hFF, 18, 64'hFF, 8});
    vecs.push_back('{1, 64'h01, 18, 64'h01, 8});
    vecs.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFF, 259, 64'hFFFF_FFFF_FFFF_FFFF, 64});
    vecs.push_back('{0, 64'h0, 259, 64'h0, 64});
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(model(0, {$urandom, $urandom}));
      vecs.push_back(model(1, {56'h0, 8'($urandom)}));
    end

    repeat (3) @(negedge clk);
    check("rst_outs_big", 64'(get(0)), 64'(RST_OUTS));
    check("rst_outs_small", 64'(get(1)), 64'(RST_OUTS));
    rst_n = 1'b1;
    clear_seq("init");

    foreach (vecs[i]) begin
      run_frame(vecs[i].sel, vecs[i].data, 1'b0, 1'b0, '0, lat, stream, rises, bad);
      check_frame($sformatf("vec%0d", i), vecs[i], lat, stream, rises, bad);
    end

    // Pattern held during a busy frame is ignored, then taken in the done cycle.
    run_frame(0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, a5, lat, stream, rises, bad);
    check_frame("b2b_first", model(0, 64'h0123_4567_89AB_CDEF), lat, stream, rises, bad);
    o = get(0);
    check("b2b_ready_in_done", 64'(o.rdy), 64'd1);
    run_frame(0, a5, 1'b1, 1'b0, '0, lat, stream, rises, bad);
    check_frame("b2b_second", model(0, a5), lat, stream, rises, bad);

    // Reset asserted mid-frame.
    drive(0, 1'b1, 64'hFFFF_0000_FFFF_0000);
    for (int i = 0; i < 2000; i++) begin
      o = get(0);
      if (o.rdy) break;
      @(negedge clk);
    end
    rises = 0;
    begin
      logic prev = 1'b0;
      for (int k = 1; k <= 400; k++) begin
        @(negedge clk);
        if (k == 1) drive(0, 1'b0, '0);
        o = get(0);
        if (o.clk && !prev) rises++;
        prev = o.clk;
        if (rises == 30) break;
      end
    end
    check("abort_bit30_reached", 64'(rises), 64'd30);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_async_big", 64'(get(0)), 64'(RST_OUTS));
    check("abort_async_small", 64'(get(1)), 64'(RST_OUTS));
    repeat (2) @(negedge clk);
    check("abort_held_big", 64'(get(0)), 64'(RST_OUTS));
    rst_n = 1'b1;
    clear_seq("abort");

    run_frame(0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, '0, lat, stream, rises, bad);
    check_frame("post_abort", model(0, 64'h1234_5678_9ABC_DEF0), lat, stream, rises, bad);

`ifdef SEG_SHIFT_AUTO_REFRESH_EN
    // Done cycle is idle cycle 1; the refresh fires at the end of idle cycle 50.
    repeat (49) @(negedge clk);
    o = get(0);
    check("refresh_not_early", 64'(o.rdy), 64'd1);
    run_frame(0, '0, 1'b1, 1'b0, '0, lat, stream, rises, bad);
    check_frame("refresh", model(0, 64'h1234_5678_9ABC_DEF0), lat, stream, rises, bad);
    repeat (49) @(negedge clk);
    drive(0, 1'b1, 64'hCAFE_F00D_DEAD_BEEF);
    run_frame(0, '0, 1'b1, 1'b0, '0, lat, stream, rises, bad);
    check_frame("refresh_override", model(0, 64'hCAFE_F00D_DEAD_BEEF), lat, stream, rises, bad);
`endif

    v = model(1, 64'h3C);
    run_frame(1, v.data, 1'b0, 1'b0, '0, lat, stream, rises, bad);
    check_frame("small_final", v, lat, stream, rises, bad);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
